// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
package disp_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_e;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/display_scanner_if.sv
// Control and display-side signals of the display scanner, grouped for port passing.
interface display_scanner_if
    import disp_pkg::*;
#(
    parameter int unsigned DIGITS = 4
);
    logic                        en;
    logic                        load;
    logic [DIGIT_W*DIGITS-1:0]   din;
    logic                        lz_en;
    logic [DIGIT_W-1:0]          num;
    logic [DIGITS-1:0]           an;
    logic                        blank;
    logic [2:0]                  digit_idx;

    modport master (
        output en, load, din, lz_en,
        input  num, an, blank, digit_idx
    );

    modport slave (
        input  en, load, din, lz_en,
        output num, an, blank, digit_idx
    );
endinterface

// File: rtl/scan_slot_counter.sv
// Slot counter shared by the blanking and show phases; tc fires on the last cycle of a slot
// and the count reloads to zero on the same edge.
module scan_slot_counter
    import disp_pkg::*;
#(
    parameter int unsigned SHOW_LEN  = 4,
    parameter int unsigned BLANK_LEN = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic step_i,
    input  logic sel_show_i,
    output logic tc_o
);
    localparam int unsigned CntW = $clog2(max_u(SHOW_LEN, BLANK_LEN) + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] limit;

    always_comb begin
        limit = sel_show_i ? CntW'(SHOW_LEN - 1) : CntW'(BLANK_LEN - 1);
        tc_o  = step_i && (cnt_q == limit);
        cnt_d = cnt_q;
        if (tc_o) begin
            cnt_d = '0;
        end else if (step_i) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexes a hex word onto a common-anode 7-segment bank with inter-digit blanking,
// tear-free frame capture and optional leading-zero suppression. All outputs are registered.
module display_scanner
    import disp_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    display_scanner_if.slave  bus
);
    localparam int unsigned DinW    = DIGIT_W * DIGITS;
    localparam logic [2:0]  LastIdx = 3'(DIGITS - 1);

    state_e              state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic [DinW-1:0]     shadow_q, shadow_d;
    logic [DinW-1:0]     disp_q, disp_d;
    logic [DIGIT_W-1:0]  num_q, num_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                blank_q, blank_d;
    logic [2:0]          digit_idx_q, digit_idx_d;

    logic                tc;
    logic [DIGITS-1:0]   supp;
    logic                upper_zero;

    scan_slot_counter #(
        .SHOW_LEN  (REFRESH_DIV),
        .BLANK_LEN (BLANK_CYCLES)
    ) u_slot_cnt (
        .clk        (clk),
        .reset      (reset),
        .step_i     (bus.en),
        .sel_show_i (state_q == ST_SHOW),
        .tc_o       (tc)
    );

    // Shadow takes every load; the display reg only refreshes as digit 0 is entered.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        disp_d   = disp_q;
        shadow_d = bus.load ? bus.din : shadow_q;
        if (bus.en && tc) begin
            unique case (state_q)
                ST_BLANK: begin
                    state_d = ST_SHOW;
                    idx_d   = (idx_q == LastIdx) ? 3'd0 : idx_q + 3'd1;
                    if (idx_d == 3'd0) begin
                        disp_d = bus.load ? bus.din : shadow_q;
                    end
                end
                ST_SHOW: state_d = ST_BLANK;
                default: state_d = ST_BLANK;
            endcase
        end
    end

    // A digit is suppressed when it and every digit to its left are zero.
    always_comb begin
        supp       = '0;
        upper_zero = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            upper_zero = upper_zero & (disp_q[DIGIT_W*i +: DIGIT_W] == '0);
            supp[i]    = bus.lz_en & upper_zero;
        end
    end

    always_comb begin
        an_d        = '1;
        blank_d     = 1'b1;
        num_d       = '0;
        digit_idx_d = idx_q;
        if (bus.en && (state_q == ST_SHOW)) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (idx_q == 3'(i)) begin
                    an_d[i] = 1'b0;
                    if (!supp[i]) begin
                        blank_d = 1'b0;
                        num_d   = disp_q[DIGIT_W*i +: DIGIT_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_BLANK;
            idx_q       <= LastIdx;
            shadow_q    <= '0;
            disp_q      <= '0;
            num_q       <= '0;
            an_q        <= '1;
            blank_q     <= 1'b1;
            digit_idx_q <= LastIdx;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            disp_q      <= disp_d;
            num_q       <= num_d;
            an_q        <= an_d;
            blank_q     <= blank_d;
            digit_idx_q <= digit_idx_d;
        end
    end

    assign bus.num       = num_q;
    assign bus.an        = an_q;
    assign bus.blank     = blank_q;
    assign bus.digit_idx = digit_idx_q;

endmodule
